// File: rtl/lsu_ctrl_if.sv
// Data-memory port between the load/store initiator (master) and the data memory (slave).
interface lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              dm_ena;
  logic              dm_w;
  logic              dm_r;
  logic              dm_sign;
  logic [2:0]        dm_size;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_ena, dm_w, dm_r, dm_sign, dm_size, dm_addr, dm_wdata,
    input  dm_rdata
  );

  modport slave (
    input  dm_ena, dm_w, dm_r, dm_sign, dm_size, dm_addr, dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator: latches one command, range/alignment checks the effective
// address, issues a single data-memory access and returns the load result.
module lsu_ctrl #(
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] base,
  input  logic [15:0] offset,
  input  logic [31:0] store_data,
  lsu_ctrl_if.master  dm,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_err
);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  size_oh_q, size_oh_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ea_q, ea_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;
  logic        calc_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      size_q      <= '0;
      size_oh_q   <= '0;
      sign_q      <= 1'b0;
      wdata_q     <= '0;
      ea_q        <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      size_oh_q   <= size_oh_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      ea_q        <= ea_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    calc_err = (size_q == 2'b11)
             | ((size_q == 2'b01) & ea_q[0])
             | ((size_q == 2'b10) & (ea_q[1:0] != 2'b00))
             | (ea_q[31:12] != DATA_BASE[31:12]);
  end

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    size_d      = size_q;
    size_oh_d   = size_oh_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    ea_d        = ea_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_store_d = is_store;
          size_d     = size;
          sign_d     = sign;
          wdata_d    = store_data;
          ea_d       = base + {{16{offset[15]}}, offset};
          unique case (size)
            2'b00:   size_oh_d = 3'b001;
            2'b01:   size_oh_d = 3'b010;
            2'b10:   size_oh_d = 3'b100;
            default: size_oh_d = 3'b000;
          endcase
          state_d = CALC;
        end
      end
      CALC: begin
        err_d   = calc_err;
        state_d = calc_err ? DONE : ISSUE;
      end
      ISSUE: state_d = is_store_q ? DONE : WAIT;
      WAIT: begin
        load_data_d = dm.dm_rdata;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked by rst so a reset during ISSUE suppresses the access at that edge.
  always_comb begin
    dm.dm_ena   = (state_q == ISSUE) & ~rst;
    dm.dm_w     = (state_q == ISSUE) & ~rst & is_store_q;
    dm.dm_r     = (state_q == ISSUE) & ~rst & ~is_store_q;
    dm.dm_sign  = sign_q & ~is_store_q;
    dm.dm_size  = size_oh_q;
    dm.dm_addr  = ea_q[ADDR_W-1:0];
    dm.dm_wdata = wdata_q;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    addr_err    = err_q;
    load_data   = load_data_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a little-endian byte memory model on the dm port.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] base;
  logic [15:0] offset;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  lsu_ctrl_if #(.ADDR_W(12)) dmif ();

  lsu_ctrl #(.DATA_BASE(32'h1001_0000), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
    .sign(sign), .base(base), .offset(offset), .store_data(store_data),
    .dm(dmif.master), .busy(busy), .done(done), .load_data(load_data),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];

  function automatic logic [31:0] mem_read(input logic [11:0] a, input logic [2:0] sz, input logic sg);
    logic [31:0] r;
    r = '0;
    if (sz[0])      r = {{24{sg & mem[a][7]}}, mem[a]};
    else if (sz[1]) r = {{16{sg & mem[a+12'd1][7]}}, mem[a+12'd1], mem[a]};
    else if (sz[2]) r = {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
    return r;
  endfunction

  always @(posedge clk) begin
    if (dmif.dm_ena && dmif.dm_w) begin
      mem[dmif.dm_addr] <= dmif.dm_wdata[7:0];
      if (dmif.dm_size[1] || dmif.dm_size[2]) mem[dmif.dm_addr+12'd1] <= dmif.dm_wdata[15:8];
      if (dmif.dm_size[2]) begin
        mem[dmif.dm_addr+12'd2] <= dmif.dm_wdata[23:16];
        mem[dmif.dm_addr+12'd3] <= dmif.dm_wdata[31:24];
      end
    end
    if (dmif.dm_ena && dmif.dm_r)
      dmif.dm_rdata <= mem_read(dmif.dm_addr, dmif.dm_size, dmif.dm_sign);
  end

  // Drives one command (start high in c0), optionally re-pulses start in cycle k
  // when repulse[k] is set, and observes 8 following cycles sampled at negedge.
  task automatic run_cmd(
    input  logic        st, input logic [1:0] sz, input logic sg,
    input  logic [31:0] b, input logic [15:0] off, input logic [31:0] sd,
    input  logic [8:0]  repulse,
    output int done_cyc, output int n_done, output int n_ena, output int n_w, output int n_r,
    output logic [2:0] o_size, output logic o_sign, output logic [11:0] o_addr,
    output logic [31:0] o_wdata, output logic [31:0] o_ld, output logic o_err
  );
    done_cyc = -1; n_done = 0; n_ena = 0; n_w = 0; n_r = 0;
    o_size = '0; o_sign = 1'b0; o_addr = '0; o_wdata = '0; o_ld = '0; o_err = 1'b0;
    @(posedge clk); #1;
    is_store = st; size = sz; sign = sg; base = b; offset = off; store_data = sd; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      start = repulse[k];
      is_store = ~st; base = 32'hFFFF_FFFF; store_data = 32'h0;
      @(negedge clk);
      if (dmif.dm_ena) begin
        n_ena++;
        o_size = dmif.dm_size; o_sign = dmif.dm_sign; o_addr = dmif.dm_addr; o_wdata = dmif.dm_wdata;
      end
      if (dmif.dm_w) n_w++;
      if (dmif.dm_r) n_r++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k; o_ld = load_data; o_err = addr_err;
        end
      end
    end
    start = 1'b0;
  endtask

  int dc, nd, ne, nw, nr;
  logic [2:0] osz;
  logic osg, oer;
  logic [11:0] oad;
  logic [31:0] owd, old;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_store = 1'b0; size = '0; sign = 1'b0;
    base = '0; offset = '0; store_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, addr_err, load_data} !== 35'd0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b err=%b ld=%h required all 0", busy, done, addr_err, load_data);
    end
    checks++;
    if ({dmif.dm_ena, dmif.dm_w, dmif.dm_r, dmif.dm_sign, dmif.dm_size, dmif.dm_addr, dmif.dm_wdata} !== 51'd0) begin
      errors++;
      $display("FAIL reset_dm: got ena=%b w=%b r=%b sg=%b sz=%b a=%h wd=%h required all 0",
               dmif.dm_ena, dmif.dm_w, dmif.dm_r, dmif.dm_sign, dmif.dm_size, dmif.dm_addr, dmif.dm_wdata);
    end
  endtask

  task automatic test_store_word();
    run_cmd(1'b1, 2'b10, 1'b0, 32'h1001_0000, 16'h0008, 32'hDEAD_BEEF, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if ({ne, nw, nr} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL sw_strobes: got ena=%0d w=%0d r=%0d required 1 1 0", ne, nw, nr);
    end
    checks++;
    if ({osz, oad, owd} !== {3'b100, 12'h008, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL sw_port: got size=%b addr=%h wdata=%h required 100 008 deadbeef", osz, oad, owd);
    end
    checks++;
    if (dc !== 3 || oer !== 1'b0) begin
      errors++; $display("FAIL sw_done: got cycle=%0d err=%b required 3 0", dc, oer);
    end
  endtask

  task automatic test_load_byte();
    run_cmd(1'b0, 2'b00, 1'b1, 32'h1001_0000, 16'h0009, 32'h0, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if ({nr, nw, osz, osg, oad} !== {32'd1, 32'd0, 3'b001, 1'b1, 12'h009}) begin
      errors++; $display("FAIL lb_port: got r=%0d w=%0d size=%b sign=%b addr=%h required 1 0 001 1 009", nr, nw, osz, osg, oad);
    end
    checks++;
    if (dc !== 4 || old !== 32'hFFFF_FFBE || oer !== 1'b0) begin
      errors++; $display("FAIL lb_data: got cycle=%0d data=%h err=%b required 4 ffffffbe 0", dc, old, oer);
    end
    run_cmd(1'b0, 2'b00, 1'b0, 32'h1001_0000, 16'h0009, 32'h0, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if (dc !== 4 || old !== 32'h0000_00BE || osg !== 1'b0) begin
      errors++; $display("FAIL lbu_data: got cycle=%0d data=%h sign=%b required 4 000000be 0", dc, old, osg);
    end
    checks++;
    if (load_data !== 32'h0000_00BE) begin
      errors++; $display("FAIL load_hold: got %h required 000000be", load_data);
    end
  endtask

  task automatic test_errors();
    run_cmd(1'b0, 2'b01, 1'b1, 32'h1001_0003, 16'h0000, 32'h0, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if (ne !== 0 || dc !== 2 || oer !== 1'b1) begin
      errors++; $display("FAIL misalign: got ena=%0d cycle=%0d err=%b required 0 2 1", ne, dc, oer);
    end
    checks++;
    if (addr_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_hold: got err=%b busy=%b required 1 0", addr_err, busy);
    end
    run_cmd(1'b0, 2'b10, 1'b0, 32'h1001_1000, 16'h0000, 32'h0, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if (ne !== 0 || dc !== 2 || oer !== 1'b1) begin
      errors++; $display("FAIL out_of_range: got ena=%0d cycle=%0d err=%b required 0 2 1", ne, dc, oer);
    end
  endtask

  task automatic test_negative_offset();
    run_cmd(1'b1, 2'b10, 1'b0, 32'h1001_0000, 16'h000C, 32'h0BAD_F00D, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if (addr_err !== 1'b0) begin
      errors++; $display("FAIL err_cleared: got %b required 0", addr_err);
    end
    run_cmd(1'b0, 2'b10, 1'b0, 32'h1001_0010, 16'hFFFC, 32'h0, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if (oad !== 12'h00C || oer !== 1'b0 || dc !== 4) begin
      errors++; $display("FAIL neg_offset: got addr=%h err=%b cycle=%0d required 00c 0 4", oad, oer, dc);
    end
    checks++;
    if (old !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL neg_offset_data: got %h required 0badf00d", old);
    end
  endtask

  task automatic test_back_to_back();
    // start re-pulsed in CALC (k=1), ISSUE (k=2) and DONE (k=3)
    run_cmd(1'b1, 2'b10, 1'b0, 32'h1001_0000, 16'h0040, 32'h1111_2222, 9'b0_0000_1110,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if (nw !== 1 || nd !== 1 || dc !== 3) begin
      errors++; $display("FAIL repulse: got w=%0d done=%0d cycle=%0d required 1 1 3", nw, nd, dc);
    end
  endtask

  task automatic test_reset_in_issue();
    run_cmd(1'b1, 2'b10, 1'b0, 32'h1001_0000, 16'h0020, 32'h1234_5678, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    @(posedge clk); #1;
    is_store = 1'b1; size = 2'b10; sign = 1'b0; base = 32'h1001_0000; offset = 16'h0020;
    store_data = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dmif.dm_ena, dmif.dm_w} !== 2'b00) begin
      errors++; $display("FAIL rst_issue_strobe: got ena=%b w=%b required 0 0", dmif.dm_ena, dmif.dm_w);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, addr_err, load_data, dmif.dm_ena, dmif.dm_w, dmif.dm_r, dmif.dm_sign,
         dmif.dm_size, dmif.dm_addr, dmif.dm_wdata} !== 86'd0) begin
      errors++; $display("FAIL rst_outputs: got busy=%b done=%b ld=%h addr=%h wd=%h required all 0",
                         busy, done, load_data, dmif.dm_addr, dmif.dm_wdata);
    end
    run_cmd(1'b0, 2'b10, 1'b0, 32'h1001_0000, 16'h0020, 32'h0, 9'd0,
            dc, nd, ne, nw, nr, osz, osg, oad, owd, old, oer);
    checks++;
    if (old !== 32'h1234_5678 || dc !== 4) begin
      errors++; $display("FAIL rst_no_write: got data=%h cycle=%0d required 12345678 4", old, dc);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_errors();
    test_negative_offset();
    test_back_to_back();
    test_reset_in_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator for the multicycle CPU; the requester side of the data-memory port.
- Accepts one load/store command from the control unit and computes the effective address.
- Checks alignment and data-segment range, then drives the data-memory enable/write/read/size/sign/address/wdata port.
- Waits out the one-cycle synchronous read latency and returns the load result with a one-cycle done pulse.

Parameters:
- DATA_BASE, 32'h1001_0000, byte address of data-segment word 0; ea[31:12] must equal DATA_BASE[31:12].
- ADDR_W, 12, width of the byte address sent to data memory (1024 words).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  command strobe, sampled only in IDLE
- is_store  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 half, 10 word, 11 illegal
- sign  input  1  load sign-extension select (lb/lh vs lbu/lhu)
- base  input  32  rs register value
- offset  input  16  immediate, sign-extended internally
- store_data  input  32  rt register value
- dm_rdata  input  32  data-memory read data, valid one edge after a read issue
- dm_ena  output  1  data-memory enable
- dm_w  output  1  write strobe
- dm_r  output  1  read strobe
- dm_sign  output  1  sign-extension select to memory
- dm_size  output  3  one-hot size: bit0 byte, bit1 half, bit2 word
- dm_addr  output  ADDR_W  byte address = ea[ADDR_W-1:0]
- dm_wdata  output  32  latched store_data, unshifted (memory places low bits)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- load_data  output  32  last load result, held until next load completes
- addr_err  output  1  valid with done: misaligned, out-of-range or illegal size

Behaviour:
- States: IDLE, CALC, ISSUE, WAIT, DONE.
- Reset: state IDLE; done, busy, addr_err, load_data = 0; all dm_* outputs = 0.
- rst has priority over every event. Reset asserted in ISSUE means no memory access on the following edge; rst in WAIT discards the read.
- IDLE: on start, latch is_store, size, sign, store_data, and ea = base + {{16{offset[15]}}, offset] (32-bit, wraps mod 2^32); go to CALC. With start low, stay in IDLE. start in any other state is ignored, never queued.
- CALC: error = (size==11) | (size==01 & ea[0]) | (size==10 & ea[1:0]!=0) | (ea[31:12]!=DATA_BASE[31:12]).
  - error: go to DONE with addr_err set; no memory access ever issued.
  - no error: go to ISSUE.
- ISSUE: the only state with dm_ena=1.
  - dm_w = is_store; dm_r = ~is_store.
  - dm_size = one-hot of size; dm_sign = sign for loads, 0 for stores.
  - dm_addr and dm_wdata are stable for the whole state.
  - Store: go to DONE. Load: go to WAIT.
- WAIT: capture dm_rdata into load_data at the exiting edge; go to DONE.
- DONE: done=1 for exactly this cycle; addr_err valid (0 on success); go to IDLE.
  - addr_err holds until the next command leaves CALC.
- Outside ISSUE: dm_ena, dm_w, dm_r = 0. dm_addr, dm_size, dm_sign and dm_wdata may hold latched values.
- Latency with start high in cycle c0: store done in c3; load done in c4 with load_data valid in c4; error done in c2.
- Back-to-back: start high in the DONE cycle is ignored; the next command is accepted one cycle after DONE.
- The block holds no data; byte/half extraction and extension are done by the memory per dm_size and dm_sign.

Test Plan:
1. sw: base=32'h1001_0000, offset=16'h0008, store_data=32'hDEADBEEF, size=10.
   - Expected: single ISSUE cycle with dm_ena=1, dm_w=1, dm_size=100, dm_addr=12'h008, dm_wdata=DEADBEEF.
   - done in c3, addr_err=0.
2. lb: sign=1 at addr 12'h009 after word DEADBEEF stored at 12'h008.
   - Expected: dm_r=1, dm_size=001, dm_sign=1; load_data=32'hFFFFFFBE at done in c4.
   - lbu (sign=0) at the same address returns 32'h000000BE.
3. lh with base=32'h1001_0003, offset=0.
   - Expected: no dm_ena pulse ever; done in c2 with addr_err=1.
   - Repeat with base=32'h1001_1000, size=10 (out of range): same response.
4. Negative offset: base=32'h1001_0010, offset=16'hFFFC, lw.
   - Expected: dm_addr=12'h00C, no error.
5. start re-pulsed in CALC, ISSUE and DONE of a store.
   - Expected: exactly one dm_w pulse and one done pulse.
6. rst asserted in ISSUE of a store to 12'h020, then lw 12'h020.
   - Expected: memory write does not occur; a subsequent lw from 12'h020 returns the prior contents; all outputs 0 the cycle after rst.
